// File: rtl/sap_loader_if.sv
// Loader bus bundle for sap_loader: start pulse, valid/ready byte stream,
// RAM write port, port-ownership select and CPU control/status lines.
// The loader connects through the slave modport; the host/system side uses master.
interface sap_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              mem_sel;
    logic              cpu_hold;
    logic              load_busy;
    logic              load_done;
    logic              load_err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, ram_we, ram_addr, ram_wdata,
               mem_sel, cpu_hold, load_busy, load_done, load_err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, ram_we, ram_addr, ram_wdata,
               mem_sel, cpu_hold, load_busy, load_done, load_err
    );
endinterface

// File: rtl/sap_loader.sv
// sap_loader: program loader and RAM-port arbiter for the SAP computer.
// Streams DEPTH bytes into RAM, then checks a trailing checksum byte; a good
// image releases the CPU (RUN), a bad one parks in ERROR with the CPU held.
// Optional feature macro: SAP_LOADER_TIMEOUT_EN adds an idle watchdog that
// aborts a stalled load to ERROR after TIMEOUT cycles without a byte.
module sap_loader #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    sap_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Reject configurations the address counter or watchdog cannot cover.
    if (DEPTH < 2 || DEPTH > (1 << ADDR_W) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("sap_loader: parameter out of range");
    end

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;
    logic              ready;
    logic              hs;
    logic              timeout_hit;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sel_q;
    logic              hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // in_ready is a pure state decode so the source sees it the cycle LOAD begins.
    assign ready    = (state == S_LOAD) || (state == S_CHECK);
    assign hs       = bus.in_valid && ready;
    assign sum_next = sum + bus.in_data;

`ifdef SAP_LOADER_TIMEOUT_EN
    logic [7:0] idle_cnt;

    // Count idle cycles inside LOAD/CHECK; any handshake or leaving those states clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!ready || hs) begin
            idle_cnt <= '0;
        end else if (idle_cnt != 8'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

    assign timeout_hit = ready && !hs && (idle_cnt == 8'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // Main FSM: state, address/checksum accumulators and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            addr    <= '0;
            sum     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted image byte.
            we_q <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    // Any settled state restarts on start; from RUN this re-clears the CPU.
                    if (bus.start) begin
                        state  <= S_LOAD;
                        addr   <= '0;
                        sum    <= '0;
                        sel_q  <= 1'b1;
                        hold_q <= 1'b1;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        we_q    <= 1'b1;
                        waddr_q <= addr;
                        wdata_q <= bus.in_data;
                        sum     <= sum_next;
                        addr    <= addr + 1'b1;
                        if (addr == LAST_ADDR) begin
                            state <= S_CHECK;
                        end
                    end else if (timeout_hit) begin
                        state  <= S_ERROR;
                        sel_q  <= 1'b0;
                        hold_q <= 1'b1;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    // Checksum byte is consumed but never written; mem_sel drops only
                    // after this edge so the last image write finishes under loader control.
                    if (hs) begin
                        sel_q  <= 1'b0;
                        busy_q <= 1'b0;
                        if (sum_next == '0) begin
                            state  <= S_RUN;
                            hold_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= S_ERROR;
                            hold_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state  <= S_ERROR;
                        sel_q  <= 1'b0;
                        hold_q <= 1'b1;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = waddr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.mem_sel   = sel_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.load_busy = busy_q;
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;

endmodule
